// File: rtl/axis_packet_checker_pkg.sv
// Shared constants and helpers for the AXI4-Stream packet checker.
// COUNT_W status width, saturating increment, all-ones strobe builder.
package axis_chk_pkg;

  localparam int COUNT_W    = 16;
  localparam int MAX_STRB_W = 128;

  function automatic logic [COUNT_W-1:0] sat_inc(
    input logic [COUNT_W-1:0] v
  );
    return (&v) ? v : v + COUNT_W'(1);
  endfunction

  // Low data_w/8 bits set; callers slice to their strobe width.
  function automatic logic [MAX_STRB_W-1:0] strb_ones(
    input int data_w
  );
    logic [MAX_STRB_W-1:0] s;
    s = '0;
    for (int i = 0; i < MAX_STRB_W; i++)
      if (i < data_w / 8) s[i] = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/axis_packet_checker_ready_shaper.sv
// Registered tready with a periodic one-cycle stall and a halt input.
// Ports: clk, rst_n (sync, active-low), halt, tready (registered).
module axis_ready_shaper #(
  parameter int STALL_PERIOD = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic halt,
  output logic tready
);

  localparam int CW =
    STALL_PERIOD > 2 ? $clog2(STALL_PERIOD) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(STALL_PERIOD >= 2 ? STALL_PERIOD - 1 : 0);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          stall;

  // tready is registered alongside the counter, so it is low
  // exactly for the cycle in which the counter sits at LAST.
  always_comb begin
    cnt_nxt = '0;
    stall   = 1'b0;
    if (STALL_PERIOD >= 2) begin
      cnt_nxt = (cnt == LAST) ? '0 : cnt + CW'(1);
      stall   = (cnt_nxt == LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      tready <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      tready <= !halt && !stall;
    end
  end

endmodule

// File: rtl/axis_packet_checker.sv
// AXI4-Stream sink: checks incrementing data, full strobes, tlast framing.
// Ports: s00_axis_* stream sink, status counters, err (sticky), done.
module axis_packet_checker
  import axis_chk_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int PKT_LEN              = 4,
  parameter int NUM_PKTS             = 8,
  parameter int STALL_PERIOD         = 0
) (
  input  logic                            s00_axis_aclk,
  input  logic                            s00_axis_aresetn,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                            s00_axis_tlast,
  input  logic                            s00_axis_tvalid,
  output logic                            s00_axis_tready,
  output logic [COUNT_W-1:0]              beat_count,
  output logic [COUNT_W-1:0]              pkt_count,
  output logic [COUNT_W-1:0]              data_err_count,
  output logic [COUNT_W-1:0]              last_err_count,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] first_bad_data,
  output logic                            err,
  output logic                            done
);

  localparam int W      = C_S_AXIS_TDATA_WIDTH;
  localparam int STRB_W = W / 8;
  localparam int POS_W  = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;

  localparam logic [MAX_STRB_W-1:0] STRB_ALL = strb_ones(W);
  localparam logic [POS_W-1:0]   POS_LAST = POS_W'(PKT_LEN - 1);
  localparam logic [COUNT_W-1:0] PKT_TGT  = COUNT_W'(NUM_PKTS);

  logic [W-1:0]       exp_data;
  logic [POS_W-1:0]   pos;
  logic               have_bad;
  logic               accept;
  logic               data_bad;
  logic               strb_bad;
  logic               at_end;
  logic               last_bad;
  logic               pkt_end;
  logic [COUNT_W-1:0] pkt_nxt;
  logic               halt;

  always_comb begin
    accept   = s00_axis_tvalid & s00_axis_tready;
    data_bad = s00_axis_tdata != exp_data;
    strb_bad = s00_axis_tstrb != STRB_ALL[STRB_W-1:0];
    at_end   = pos == POS_LAST;
    last_bad = s00_axis_tlast != at_end;
    pkt_end  = accept & (s00_axis_tlast | at_end);
    pkt_nxt  = pkt_end ? sat_inc(pkt_count) : pkt_count;
    // Feeds the ready register so tready drops on the
    // same edge that accepts the completing beat.
    halt     = done | (pkt_nxt == PKT_TGT);
  end

  axis_ready_shaper #(
    .STALL_PERIOD (STALL_PERIOD)
  ) u_shaper (
    .clk    (s00_axis_aclk),
    .rst_n  (s00_axis_aresetn),
    .halt   (halt),
    .tready (s00_axis_tready)
  );

  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      exp_data       <= '0;
      pos            <= '0;
      have_bad       <= 1'b0;
      beat_count     <= '0;
      pkt_count      <= '0;
      data_err_count <= '0;
      last_err_count <= '0;
      first_bad_data <= '0;
      err            <= 1'b0;
      done           <= 1'b0;
    end else begin
      pkt_count <= pkt_nxt;
      done      <= halt;
      if (accept) begin
        beat_count <= sat_inc(beat_count);
        exp_data   <= s00_axis_tdata + W'(1);
        pos        <= pkt_end ? '0 : pos + POS_W'(1);
        if (data_bad || strb_bad)
          data_err_count <= sat_inc(data_err_count);
        if (last_bad)
          last_err_count <= sat_inc(last_err_count);
        if (data_bad || strb_bad || last_bad)
          err <= 1'b1;
        if (data_bad && !have_bad) begin
          first_bad_data <= s00_axis_tdata;
          have_bad       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_packet_checker.sv
// Randomized bench for axis_packet_checker, two instances.
// Instance 0 never stalls, instance 1 stalls one cycle in four.
module tb_axis_packet_checker;

  localparam int W  = 32;
  localparam int PL = 4;
  localparam int NP = 8;

  typedef struct {
    logic [W-1:0] d;
    logic [3:0]   s;
    logic         l;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn   [2];
  logic         tvalid [2];
  logic         tlast  [2];
  logic [W-1:0] tdata  [2];
  logic [3:0]   tstrb  [2];
  logic         tready [2];
  logic [15:0]  bcnt   [2];
  logic [15:0]  pcnt   [2];
  logic [15:0]  dcnt   [2];
  logic [15:0]  lcnt   [2];
  logic [W-1:0] fbd    [2];
  logic         err    [2];
  logic         done   [2];

  axis_packet_checker #(
    .C_S_AXIS_TDATA_WIDTH (W),
    .PKT_LEN (PL), .NUM_PKTS (NP), .STALL_PERIOD (0)
  ) u_nost (
    .s00_axis_aclk (clk), .s00_axis_aresetn (rstn[0]),
    .s00_axis_tdata (tdata[0]), .s00_axis_tstrb (tstrb[0]),
    .s00_axis_tlast (tlast[0]), .s00_axis_tvalid (tvalid[0]),
    .s00_axis_tready (tready[0]), .beat_count (bcnt[0]),
    .pkt_count (pcnt[0]), .data_err_count (dcnt[0]),
    .last_err_count (lcnt[0]), .first_bad_data (fbd[0]),
    .err (err[0]), .done (done[0])
  );

  axis_packet_checker #(
    .C_S_AXIS_TDATA_WIDTH (W),
    .PKT_LEN (PL), .NUM_PKTS (NP), .STALL_PERIOD (4)
  ) u_st (
    .s00_axis_aclk (clk), .s00_axis_aresetn (rstn[1]),
    .s00_axis_tdata (tdata[1]), .s00_axis_tstrb (tstrb[1]),
    .s00_axis_tlast (tlast[1]), .s00_axis_tvalid (tvalid[1]),
    .s00_axis_tready (tready[1]), .beat_count (bcnt[1]),
    .pkt_count (pcnt[1]), .data_err_count (dcnt[1]),
    .last_err_count (lcnt[1]), .first_bad_data (fbd[1]),
    .err (err[1]), .done (done[1])
  );

  int n_chk  = 0;
  int n_pass = 0;
  int k [2];
  bit exp_done [2];
  beat_t stim [$];

  // reference model state: one walk over the accepted beats
  int           m_beats, m_pkts, m_derr, m_lerr, m_pos;
  logic [W-1:0] m_exp, m_fbd;
  bit           m_have, m_done;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  function automatic void model_reset();
    m_beats = 0; m_pkts = 0; m_derr = 0; m_lerr = 0;
    m_pos = 0; m_exp = '0; m_fbd = '0;
    m_have = 0; m_done = 0;
  endfunction

  function automatic void model_step(beat_t b);
    bit eop;
    m_beats++;
    if (b.d != m_exp || b.s != 4'hF) m_derr++;
    if (b.d != m_exp && !m_have) begin
      m_fbd = b.d; m_have = 1;
    end
    eop = (m_pos == PL - 1);
    if (b.l != eop) m_lerr++;
    if (b.l || eop) begin
      m_pkts++; m_pos = 0;
    end else m_pos++;
    m_exp = b.d + 1;
    m_done = (m_pkts == NP);
  endfunction

  function automatic bit ready_exp(int u);
    if (exp_done[u]) return 1'b0;
    if (u == 0) return 1'b1;
    return (k[1] % 4) != 3;
  endfunction

  always @(posedge clk)
    for (int u = 0; u < 2; u++)
      k[u] <= rstn[u] ? k[u] + 1 : 0;

  always @(posedge clk) begin
    #3;
    for (int u = 0; u < 2; u++)
      if (rstn[u] && k[u] > 0)
        check(u ? "tready_st" : "tready_nost",
              tready[u], ready_exp(u));
  end

  task automatic do_reset(int u);
    @(negedge clk);
    rstn[u] = 0; tvalid[u] = 0; tlast[u] = 0;
    tdata[u] = $urandom; tstrb[u] = 4'hF;
    exp_done[u] = 0;
    @(posedge clk); #1;
    check("rst_tready", tready[u], 0);
    check("rst_beats", bcnt[u], 0);
    check("rst_pkts", pcnt[u], 0);
    check("rst_derr", dcnt[u], 0);
    check("rst_lerr", lcnt[u], 0);
    check("rst_fbd", fbd[u], 0);
    check("rst_err", err[u], 0);
    check("rst_done", done[u], 0);
    @(negedge clk);
    rstn[u] = 1;
    model_reset();
  endtask

  task automatic build(int n, int md, int off);
    beat_t b;
    stim.delete();
    for (int i = 0; i < n; i++) begin
      b.d = i; b.s = 4'hF; b.l = (i % md) == off;
      stim.push_back(b);
    end
  endtask

  task automatic build_rand(int n);
    beat_t b;
    logic [W-1:0] v;
    stim.delete();
    v = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) v = $urandom;
      b.d = v;
      b.s = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'hF;
      b.l = ((i % 4) == 3) ^ ($urandom_range(0, 7) == 0);
      stim.push_back(b);
      v = v + 1;
    end
  endtask

  task automatic run(int u);
    int guard;
    foreach (stim[i]) begin
      if (m_done) break;
      repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0)
      begin
        @(negedge clk);
        tvalid[u] = 0; tdata[u] = $urandom;
        tlast[u] = 1'($urandom); tstrb[u] = 4'($urandom);
      end
      @(negedge clk);
      tvalid[u] = 1; tdata[u] = stim[i].d;
      tstrb[u] = stim[i].s; tlast[u] = stim[i].l;
      guard = 0;
      while (!tready[u] && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      if (!tready[u]) begin
        check("ready_timeout", tready[u], 1);
        break;
      end
      @(posedge clk); #1;
      model_step(stim[i]);
      exp_done[u] = m_done;
      check("beat_count", bcnt[u], m_beats);
      check("pkt_count", pcnt[u], m_pkts);
      check("data_err", dcnt[u], m_derr);
      check("last_err", lcnt[u], m_lerr);
      check("done", done[u], m_done);
    end
    if (m_done) begin
      @(negedge clk);
      tvalid[u] = 1; tdata[u] = m_exp;
      tstrb[u] = 4'hF; tlast[u] = 0;
      repeat (6) @(negedge clk);
      check("no_accept_after_done", bcnt[u], m_beats);
    end
    @(negedge clk);
    tvalid[u] = 0;
    repeat (2) @(posedge clk);
    #1;
    check("fin_beats", bcnt[u], m_beats);
    check("fin_pkts", pcnt[u], m_pkts);
    check("fin_derr", dcnt[u], m_derr);
    check("fin_lerr", lcnt[u], m_lerr);
    check("fin_fbd", fbd[u], m_fbd);
    check("fin_err", err[u], (m_derr + m_lerr) != 0);
    check("fin_done", done[u], m_done);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rstn[u] = 0; tvalid[u] = 0; tlast[u] = 0;
      tdata[u] = '0; tstrb[u] = 4'hF; exp_done[u] = 0;
    end
    model_reset();
    for (int u = 0; u < 2; u++) begin
      do_reset(u);
      build(32, 4, 3);
      run(u);
      check("clean_beats", bcnt[u], 32);
      check("clean_pkts", pcnt[u], 8);
      check("clean_err", err[u], 0);

      do_reset(u);
      build(12, 3, 2);
      run(u);
      check("early_lerr", lcnt[u], 4);
      check("early_pkts", pcnt[u], 4);
      check("early_derr", dcnt[u], 0);

      do_reset(u);
      build(32, 4, 3);
      foreach (stim[i]) if (i >= 3) stim[i].d = i + 2;
      run(u);
      check("skip_derr", dcnt[u], 1);
      check("skip_fbd", fbd[u], 5);
      check("skip_err", err[u], 1);
      check("skip_pkts", pcnt[u], 8);

      do_reset(u);
      build(32, 4, 3);
      stim[9].s = 4'b0001;
      run(u);
      check("strb_derr", dcnt[u], 1);
      check("strb_fbd", fbd[u], 0);

      do_reset(u);
      build(2, 4, 3);
      run(u);
      do_reset(u);
      build(32, 4, 3);
      run(u);
      check("rstmid_beats", bcnt[u], 32);
      check("rstmid_pkts", pcnt[u], 8);
      check("rstmid_err", err[u], 0);

      for (int r = 0; r < 3; r++) begin
        do_reset(u);
        build_rand(40);
        run(u);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
